// File: rtl/layer_seq_pkg.sv
// layer_seq_pkg: shared types and helpers for the layer sequencer.
package layer_seq_pkg;
    localparam int ENTRY_DIM_W = 16;

    typedef enum logic [1:0] {CONV3 = 2'd0, DWS = 2'd1, PW = 2'd2} layer_kind_t;
    typedef enum logic [2:0] {IDLE, CFG, ISSUE, WAIT, NEXT, DONE} state_t;

    typedef struct packed {
        logic [ENTRY_DIM_W-1:0] out_c;
        logic [1:0]             stride;
        layer_kind_t            kind;
    } layer_entry_t;

    function automatic logic [31:0] ceil_div_stride(input logic [31:0] x, input logic [1:0] s);
        return s == 2'd2 ? (x >> 1) + {31'd0, x[0]} : x;
    endfunction
endpackage

// File: rtl/layer_seq_ctrl_if.sv
// layer_seq_ctrl_if: runner-side bundle carrying the layer/tile descriptor and run handshake.
interface layer_seq_ctrl_if #(parameter int DIM_W = 16, parameter int ADDR_W = 32);
    logic              run_start;
    logic              run_done;
    logic [1:0]        layer_kind;
    logic [DIM_W-1:0]  layer_idx;
    logic [DIM_W-1:0]  cur_in_h, cur_in_w, cur_in_c;
    logic [DIM_W-1:0]  cur_out_h, cur_out_w, cur_out_c, cur_stride;
    logic [DIM_W-1:0]  tile_out_row, tile_out_col, tile_out_h, tile_out_w;
    logic [ADDR_W-1:0] in_base_addr, out_base_addr;

    modport master (
        output run_start, layer_kind, layer_idx, cur_in_h, cur_in_w, cur_in_c,
               cur_out_h, cur_out_w, cur_out_c, cur_stride,
               tile_out_row, tile_out_col, tile_out_h, tile_out_w,
               in_base_addr, out_base_addr,
        input  run_done
    );
    modport slave (
        input  run_start, layer_kind, layer_idx, cur_in_h, cur_in_w, cur_in_c,
               cur_out_h, cur_out_w, cur_out_c, cur_stride,
               tile_out_row, tile_out_col, tile_out_h, tile_out_w,
               in_base_addr, out_base_addr,
        output run_done
    );
endinterface

// File: rtl/tile_iter.sv
// tile_iter: raster walk (column fastest) over a layer's output tiles with edge clipping.
module tile_iter #(
    parameter int DIM_W  = 16,
    parameter int IDX_W  = 16,
    parameter int TILE_H = 16,
    parameter int TILE_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             step,
    input  logic [DIM_W-1:0] out_h,
    input  logic [DIM_W-1:0] out_w,
    output logic [DIM_W-1:0] row,
    output logic [DIM_W-1:0] col,
    output logic [DIM_W-1:0] th,
    output logic [DIM_W-1:0] tw,
    output logic [IDX_W-1:0] idx,
    output logic             last
);
    logic [DIM_W-1:0] rem_h, rem_w;
    logic             row_end;

    assign rem_h   = out_h - row;
    assign rem_w   = out_w - col;
    assign th      = rem_h < DIM_W'(TILE_H) ? rem_h : DIM_W'(TILE_H);
    assign tw      = rem_w < DIM_W'(TILE_W) ? rem_w : DIM_W'(TILE_W);
    assign row_end = rem_w <= DIM_W'(TILE_W);
    assign last    = row_end && rem_h <= DIM_W'(TILE_H);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
            idx <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
            idx <= '0;
        end else if (step) begin
            col <= row_end ? '0 : col + DIM_W'(TILE_W);
            row <= row_end ? row + DIM_W'(TILE_H) : row;
            idx <= idx + IDX_W'(1);
        end
    end
endmodule

// File: rtl/layer_seq_ctrl.sv
// layer_seq_ctrl: programmable per-layer tile sequencer driving the conv/DWS/PW runners.
// Define LAYER_SEQ_PERF_EN to add the perf_cycles / perf_skipped counters.
module layer_seq_ctrl
    import layer_seq_pkg::*;
#(
    parameter int DIM_W       = 16,
    parameter int ADDR_W      = 32,
    parameter int MASK_ADDR_W = 16,
    parameter int MAX_LAYERS  = 32,
    parameter int TILE_H      = 16,
    parameter int TILE_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic                          aborted,
    input  logic                          tbl_wr_en,
    input  logic [$clog2(MAX_LAYERS)-1:0] tbl_wr_addr,
    input  logic [DIM_W-1:0]              tbl_wr_out_c,
    input  logic [1:0]                    tbl_wr_stride,
    input  logic [1:0]                    tbl_wr_kind,
    input  logic [$clog2(MAX_LAYERS):0]   cfg_num_layers,
    input  logic [DIM_W-1:0]              cfg_in_h,
    input  logic [DIM_W-1:0]              cfg_in_w,
    input  logic [DIM_W-1:0]              cfg_in_c,
    input  logic [ADDR_W-1:0]             cfg_fm_base0,
    input  logic [ADDR_W-1:0]             cfg_fm_base1,
    input  logic                          tile_skip_en,
    output logic [MASK_ADDR_W-1:0]        tile_mask_addr,
    input  logic                          tile_mask_data,
    layer_seq_ctrl_if.master              run
`ifdef LAYER_SEQ_PERF_EN
    ,
    output logic [31:0]                   perf_cycles,
    output logic [MASK_ADDR_W-1:0]        perf_skipped
`endif
);
    state_t                 state;
    layer_entry_t           tbl [MAX_LAYERS];
    layer_entry_t           ent;
    logic [MASK_ADDR_W-1:0] mask_base, tile_idx;
    logic                   base_sel, keep, step, last;
    logic [DIM_W-1:0]       nxt_oh, nxt_ow, last_layer;
    logic [DIM_W-1:0]       t_row, t_col, t_h, t_w;

    // Strides other than 2 collapse to 1 so the CFG divide only ever sees 1 or 2.
    always_ff @(posedge clk)
        if (tbl_wr_en && state == IDLE)
            tbl[tbl_wr_addr] <= '{out_c:  ENTRY_DIM_W'(tbl_wr_out_c),
                                  stride: tbl_wr_stride == 2'd2 ? 2'd2 : 2'd1,
                                  kind:   layer_kind_t'(tbl_wr_kind)};

    assign ent            = tbl[run.layer_idx[$clog2(MAX_LAYERS)-1:0]];
    assign nxt_oh         = DIM_W'(ceil_div_stride(32'(run.cur_in_h), ent.stride));
    assign nxt_ow         = DIM_W'(ceil_div_stride(32'(run.cur_in_w), ent.stride));
    assign last_layer     = DIM_W'(cfg_num_layers) - DIM_W'(1);
    assign keep           = !tile_skip_en || tile_mask_data;
    assign step           = !abort && ((state == ISSUE && !keep) || (state == WAIT && run.run_done));
    assign busy           = state != IDLE;
    assign tile_mask_addr = mask_base + tile_idx;
    assign run.in_base_addr  = base_sel ? cfg_fm_base1 : cfg_fm_base0;
    assign run.out_base_addr = base_sel ? cfg_fm_base0 : cfg_fm_base1;
    assign run.tile_out_row  = t_row;
    assign run.tile_out_col  = t_col;
    assign run.tile_out_h    = t_h;
    assign run.tile_out_w    = t_w;

    tile_iter #(.DIM_W(DIM_W), .IDX_W(MASK_ADDR_W), .TILE_H(TILE_H), .TILE_W(TILE_W)) u_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == CFG),
        .step  (step),
        .out_h (run.cur_out_h),
        .out_w (run.cur_out_w),
        .row   (t_row),
        .col   (t_col),
        .th    (t_h),
        .tw    (t_w),
        .idx   (tile_idx),
        .last  (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            done           <= 1'b0;
            aborted        <= 1'b0;
            run.run_start  <= 1'b0;
            run.layer_idx  <= '0;
            run.layer_kind <= '0;
            run.cur_in_h   <= '0;
            run.cur_in_w   <= '0;
            run.cur_in_c   <= '0;
            run.cur_out_h  <= '0;
            run.cur_out_w  <= '0;
            run.cur_out_c  <= '0;
            run.cur_stride <= '0;
            mask_base      <= '0;
            base_sel       <= 1'b0;
        end else begin
            done          <= 1'b0;
            aborted       <= 1'b0;
            run.run_start <= 1'b0;
            if (abort && state != IDLE) begin
                state   <= IDLE;
                aborted <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        run.cur_in_h  <= cfg_in_h;
                        run.cur_in_w  <= cfg_in_w;
                        run.cur_in_c  <= cfg_in_c;
                        run.layer_idx <= '0;
                        mask_base     <= '0;
                        base_sel      <= 1'b0;
                        state         <= cfg_num_layers == '0 ? DONE : CFG;
                    end
                    CFG: begin
                        run.cur_out_h  <= nxt_oh;
                        run.cur_out_w  <= nxt_ow;
                        run.cur_out_c  <= DIM_W'(ent.out_c);
                        run.cur_stride <= DIM_W'(ent.stride);
                        run.layer_kind <= ent.kind;
                        state          <= (nxt_oh == '0 || nxt_ow == '0) ? NEXT : ISSUE;
                    end
                    ISSUE: begin
                        run.run_start <= keep;
                        state         <= keep ? WAIT : (last ? NEXT : ISSUE);
                    end
                    WAIT: if (run.run_done) state <= last ? NEXT : ISSUE;
                    // tile_idx now holds this layer's tile count, so it advances the mask base.
                    NEXT: begin
                        run.cur_in_h  <= run.cur_out_h;
                        run.cur_in_w  <= run.cur_out_w;
                        run.cur_in_c  <= run.cur_out_c;
                        base_sel      <= !base_sel;
                        mask_base     <= mask_base + tile_idx;
                        run.layer_idx <= run.layer_idx == last_layer ? run.layer_idx : run.layer_idx + DIM_W'(1);
                        state         <= run.layer_idx == last_layer ? DONE : CFG;
                    end
                    DONE: begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef LAYER_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles  <= '0;
            perf_skipped <= '0;
        end else if (state == IDLE) begin
            perf_cycles  <= start ? '0 : perf_cycles;
            perf_skipped <= start ? '0 : perf_skipped;
        end else begin
            perf_cycles  <= perf_cycles + 32'd1;
            perf_skipped <= perf_skipped + MASK_ADDR_W'(state == ISSUE && !keep && !abort);
        end
    end
`endif
endmodule
